// File: rtl/diff2_pkg.sv
// Shared types and defaults for the diff2 stream scheduler.
//   hist_t     : per-channel 2-deep sample history, {h1 (older), h0 (newer)}
//   cnt_t      : per-channel warm-up counter, saturating at CNT_PRIMED
//   cnt_inc()  : saturating increment of cnt_t
package diff2_pkg;

  localparam int NCH_DEFAULT  = 4;
  localparam int ID_W_DEFAULT = 2;

  typedef logic [1:0] hist_t;
  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_PRIMED = 2'd2;

  function automatic cnt_t cnt_inc(input cnt_t c);
    return (c == CNT_PRIMED) ? CNT_PRIMED : c + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered search pointer.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-low reset (pointer to 0, grant forced to 0)
//   req      : per-channel request vector
//   adv      : consume strobe; pointer moves past the granted channel
//   grant    : one-hot grant, combinational from req and pointer
//   grant_id : binary index of the granted channel (0 when no grant)
module rr_arbiter
  import diff2_pkg::*;
#(
  parameter int NCH  = NCH_DEFAULT,
  parameter int ID_W = ID_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  req,
  input  logic            adv,
  output logic [NCH-1:0]  grant,
  output logic [ID_W-1:0] grant_id
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;
  logic            found;

  // Search upward from the pointer with wrap; first asserted request wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = ID_W'((32'(ptr) + k) % NCH);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
    if (!reset) begin
      grant    = '0;
      grant_id = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (grant_id == ID_W'(NCH - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/diff2_stream_scheduler.sv
// Shares one "current bit differs from second-last bit" detector among NCH
// serial streams. A round-robin arbiter grants one stream per cycle; each
// stream keeps its own 2-deep history and warm-up counter, so every stream
// sees an independent detector. Results are registered and tagged.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous active-low reset
//   req        : per-channel request, held with bit_in stable until granted
//   bit_in     : per-channel sample bit
//   clear      : per-channel history clear pulse
//   grant      : one-hot grant (combinational)
//   res_valid  : registered result strobe
//   res_ch     : channel of the result
//   res_out    : bit_in XOR sample from two samples earlier
//   res_primed : channel had at least 2 prior samples
module diff2_stream_scheduler
  import diff2_pkg::*;
#(
  parameter int NCH  = NCH_DEFAULT,
  parameter int ID_W = ID_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  req,
  input  logic [NCH-1:0]  bit_in,
  input  logic [NCH-1:0]  clear,
  output logic [NCH-1:0]  grant,
  output logic            res_valid,
  output logic [ID_W-1:0] res_ch,
  output logic            res_out,
  output logic            res_primed
);

  logic [ID_W-1:0] grant_id;
  logic            adv;
  hist_t           hist [NCH];
  cnt_t            cnt  [NCH];
  hist_t           sel_hist;
  cnt_t            sel_cnt;
  logic            sel_bit;

  assign adv = |grant;

  rr_arbiter #(
    .NCH  (NCH),
    .ID_W (ID_W)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .adv      (adv),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Granted channel's state as seen after a same-cycle clear: a colliding
  // clear wipes the history before the sample is evaluated against it.
  always_comb begin
    sel_bit  = bit_in[grant_id];
    sel_hist = clear[grant_id] ? '0 : hist[grant_id];
    sel_cnt  = clear[grant_id] ? '0 : cnt[grant_id];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      res_valid  <= 1'b0;
      res_ch     <= '0;
      res_out    <= 1'b0;
      res_primed <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        hist[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      res_valid <= adv;
      if (adv) begin
        res_ch     <= grant_id;
        res_out    <= sel_bit ^ sel_hist[1];
        res_primed <= (sel_cnt == CNT_PRIMED);
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        if (adv && grant_id == ID_W'(i)) begin
          hist[i] <= {sel_hist[0], sel_bit};
          cnt[i]  <= cnt_inc(sel_cnt);
        end else if (clear[i]) begin
          hist[i] <= '0;
          cnt[i]  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_diff2_stream_scheduler.sv
module tb_diff2_stream_scheduler;

  localparam int NCH  = 4;
  localparam int ID_W = 2;

  logic            clk    = 1'b0;
  logic            reset  = 1'b0;
  logic [NCH-1:0]  req    = '0;
  logic [NCH-1:0]  bit_in = '0;
  logic [NCH-1:0]  clear  = '0;
  logic [NCH-1:0]  grant;
  logic            res_valid;
  logic [ID_W-1:0] res_ch;
  logic            res_out;
  logic            res_primed;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  diff2_stream_scheduler #(
    .NCH  (NCH),
    .ID_W (ID_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .bit_in     (bit_in),
    .clear      (clear),
    .grant      (grant),
    .res_valid  (res_valid),
    .res_ch     (res_ch),
    .res_out    (res_out),
    .res_primed (res_primed)
  );

  typedef struct {
    logic       rst;
    logic [3:0] r;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] g;
    logic       v;
    logic [1:0] ch;
    logic       o;
    logic       p;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] r, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] g, input logic v,
                              input logic [1:0] ch, input logic o, input logic p);
    vec_t t;
    t.rst = rst; t.r = r; t.b = b; t.c = c; t.g = g;
    t.v = v; t.ch = ch; t.o = o; t.p = p;
    return t;
  endfunction

  // Reference model: each stream keeps the list of its samples since the
  // last clear/reset; the detector compares against the second-last one.
  int         m_ptr = 0;
  bit         m_hist[NCH][$];
  logic       m_v = 1'b0;
  logic [1:0] m_ch = '0;
  logic       m_o = 1'b0;
  logic       m_p = 1'b0;

  function automatic logic [NCH-1:0] m_grant(input logic rst, input logic [NCH-1:0] r);
    logic [NCH-1:0] one;
    one = 1;
    if (!rst) return '0;
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = (m_ptr + k) % NCH;
      if (r[idx]) return one << idx;
    end
    return '0;
  endfunction

  task automatic m_edge(input logic rst, input logic [NCH-1:0] r,
                        input logic [NCH-1:0] b, input logic [NCH-1:0] c);
    logic [NCH-1:0] g;
    int sel;
    int n;
    if (!rst) begin
      m_ptr = 0; m_v = 1'b0; m_ch = '0; m_o = 1'b0; m_p = 1'b0;
      for (int i = 0; i < NCH; i++) m_hist[i].delete();
    end else begin
      g = m_grant(rst, r);
      for (int i = 0; i < NCH; i++) if (c[i]) m_hist[i].delete();
      if (g != 0) begin
        sel = 0;
        for (int i = 0; i < NCH; i++) if (g[i]) sel = i;
        n    = m_hist[sel].size();
        m_o  = b[sel] ^ ((n >= 2) ? m_hist[sel][n-2] : 1'b0);
        m_p  = (n >= 2);
        m_hist[sel].push_back(b[sel]);
        if (m_hist[sel].size() > 2) void'(m_hist[sel].pop_front());
        m_v   = 1'b1;
        m_ch  = 2'(sel);
        m_ptr = (sel + 1) % NCH;
      end else begin
        m_v = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle: inputs set after the previous edge, grant sampled at the
  // falling edge, registered outputs sampled 1 time unit after the rising edge.
  task automatic apply(input logic rst, input logic [3:0] r, input logic [3:0] b,
                       input logic [3:0] c, output logic [3:0] g_model,
                       output logic [3:0] g_dut);
    reset = rst; req = r; bit_in = b; clear = c;
    @(negedge clk);
    g_dut   = grant;
    g_model = m_grant(rst, r);
    m_edge(rst, r, b, c);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] gm, gd;
    logic [3:0] r_cur, b_cur, c_cur;
    logic       rst_cur;
    logic [3:0] onehot;

    // Reset: grant stays low even with requests pending.
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0));
    // Single stream on ch0: bits 0,0,0,1,0,1,0,0.
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 1, 1));
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 1, 1));
    // Reset, then all four requesting for 8 cycles.
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) begin
      onehot = 4'b0001 << (k % 4);
      tbl.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, onehot, 1, 2'(k % 4), 0, 0));
    end
    // Clear ch1/ch2 while idle (result fields hold), then interleave
    // ch1 bits 1,1,1 with ch2 bits 0,1,0.
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 0, 3, 0, 0));
    tbl.push_back(mk(1, 4'b0110, 4'b0010, 4'b0000, 4'b0010, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'b0110, 4'b0010, 4'b0000, 4'b0100, 1, 2, 0, 0));
    tbl.push_back(mk(1, 4'b0110, 4'b0110, 4'b0000, 4'b0010, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'b0110, 4'b0110, 4'b0000, 4'b0100, 1, 2, 1, 0));
    tbl.push_back(mk(1, 4'b0110, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 2, 0, 1));
    // Prime ch0 to {1,1}, then clear colliding with a grant, then 0,1.
    tbl.push_back(mk(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 1, 1));
    tbl.push_back(mk(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 1, 1));
    tbl.push_back(mk(1, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0, 1));
    // Idle for 3 cycles, then 3 requesters with a mid-stream reset.
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0111, 4'b0111, 4'b0000, 4'b0010, 1, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0111, 4'b0111, 4'b0000, 4'b0001, 1, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0111, 4'b0111, 4'b0000, 4'b0010, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'b0111, 4'b0111, 4'b0000, 4'b0100, 1, 2, 1, 0));
    tbl.push_back(mk(1, 4'b0111, 4'b0111, 4'b0000, 4'b0001, 1, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0111, 4'b0111, 4'b0000, 4'b0010, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'b0111, 4'b0111, 4'b0000, 4'b0100, 1, 2, 1, 0));
    tbl.push_back(mk(1, 4'b0111, 4'b0111, 4'b0000, 4'b0001, 1, 0, 0, 1));

    foreach (tbl[k]) begin
      apply(tbl[k].rst, tbl[k].r, tbl[k].b, tbl[k].c, gm, gd);
      chk($sformatf("vec%0d grant", k),      32'(gd),         32'(tbl[k].g));
      chk($sformatf("vec%0d res_valid", k),  32'(res_valid),  32'(tbl[k].v));
      if (tbl[k].v || !tbl[k].rst) begin
        chk($sformatf("vec%0d res_ch", k),   32'(res_ch),     32'(tbl[k].ch));
      end
      chk($sformatf("vec%0d res_out", k),    32'(res_out),    32'(tbl[k].o));
      chk($sformatf("vec%0d res_primed", k), 32'(res_primed), 32'(tbl[k].p));
    end

    // Randomized phase: requesters obey the hold-until-granted protocol.
    apply(1'b0, 4'b0000, 4'b0000, 4'b0000, gm, gd);
    r_cur = '0; b_cur = '0; gm = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!(r_cur[i] && !gm[i])) begin
          r_cur[i] = ($urandom_range(3) != 0);
          b_cur[i] = 1'($urandom_range(1));
        end
        c_cur[i] = ($urandom_range(7) == 0);
      end
      rst_cur = ($urandom_range(49) != 0);
      apply(rst_cur, r_cur, b_cur, c_cur, gm, gd);
      chk($sformatf("rnd%0d grant", cyc),      32'(gd),         32'(gm));
      chk($sformatf("rnd%0d res_valid", cyc),  32'(res_valid),  32'(m_v));
      chk($sformatf("rnd%0d res_ch", cyc),     32'(res_ch),     32'(m_ch));
      chk($sformatf("rnd%0d res_out", cyc),    32'(res_out),    32'(m_o));
      chk($sformatf("rnd%0d res_primed", cyc), 32'(res_primed), 32'(m_p));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/diff2_stream_scheduler.md
Name: diff2_stream_scheduler

Overview:
- Shares one "current bit differs from second-last bit" detector among NCH serial bit streams.
- A round-robin arbiter grants one requester per cycle.
- Per-channel 2-deep history and a warm-up counter are kept locally, so each stream sees an independent detector.
- The result is registered and tagged with its channel ID. The block sits between serial sources and any consumer of per-stream difference flags.

Parameters:
- NCH, 4, number of requesting streams (2..16)
- ID_W, 2, channel-ID width, equal to ceil(log2(NCH))

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset; sampled on the rising clk edge, 0 = reset
- req  input  NCH  per-channel request; held high with bit_in stable until granted
- bit_in  input  NCH  per-channel sample bit
- clear  input  NCH  per-channel history clear, one-cycle pulse
- grant  output  NCH  one-hot grant, combinational from req and the RR pointer
- res_valid  output  1  registered result strobe
- res_ch  output  ID_W  channel of the result
- res_out  output  1  bit_in XOR history bit from two samples earlier
- res_primed  output  1  1 when the channel had at least 2 prior samples

Behaviour:
- Reset (reset==0 at an edge):
  - res_valid, res_ch, res_out and res_primed go to 0.
  - RR pointer goes to 0.
  - All histories {h1,h0} and all counters cnt go to 0.
  - grant is all-zero while reset is low.
- Arbitration:
  - grant picks the first asserted req at or after pointer, searching upward with wrap from NCH-1 to 0.
  - If req==0, grant is 0.
- Sample consumption:
  - A sample is consumed at the edge where req[i] & grant[i] is 1.
  - Requesters drop req or present the next bit afterwards; an ungranted requester holds req and bit_in.
- At a consume edge for channel i:
  - res_valid becomes 1 and res_ch becomes i.
  - res_out becomes bit_in[i] ^ h1[i], using the old h1.
  - res_primed becomes (cnt[i] == 2), using the old cnt.
  - History shifts: h1[i] takes h0[i], and h0[i] takes bit_in[i].
  - cnt[i] increments, saturating at 2.
  - Pointer becomes (i+1) mod NCH.
- Edge with no grant:
  - res_valid becomes 0.
  - res_ch, res_out and res_primed hold their previous values.
  - Pointer holds.
- Latency: exactly one cycle from the consume edge to the result. Throughput: one result per cycle, total.
- clear[i] without a grant to i: h1[i], h0[i] and cnt[i] become 0. Other channels are unaffected.
- clear[i] in the same cycle as a grant to i: clear applies first. The sample is evaluated against zero history:
  - res_out = bit_in[i]
  - res_primed = 0
  - New history: h1=0, h0=bit_in[i]
  - New cnt = 1
- Starvation bound: a requester that holds req waits at most NCH-1 cycles.
- reset low mid-stream takes priority over everything. Any in-flight result is discarded (res_valid=0 on the next cycle).
- Channel fairness is unaffected by clear.

Decomposition:
- Shared package diff2_pkg holds:
  - localparams NCH_DEFAULT=4 and ID_W_DEFAULT=2
  - typedef hist_t: 2-bit {h1,h0}
  - typedef cnt_t: 2-bit saturating counter, with constant CNT_PRIMED=2
- One sub-module, rr_arbiter:
  - inputs: clk, reset, req, adv (consume strobe)
  - outputs: one-hot grant, binary grant_id
  - contains the pointer register
- The history/XOR datapath stays in the top module.

Test Plan:
- Single-stream detection: drive only ch0 with req held high and bit sequence 0,0,0,1,0,1,0,0. Required:
  - res_valid=1 each following cycle
  - res_ch=0
  - res_out = 0,0,0,1,0,0,0,1
  - res_primed = 0,0,1,1,1,1,1,1
- Round-robin fairness: req=4'b1111 held for 8 cycles. Required:
  - grant sequence 0001,0010,0100,1000,0001,... one-hot
  - res_ch sequence 0,1,2,3,0,1,2,3
  - no cycle where res_valid=0
- Independent histories: ch1 gets bits 1,1,1 and ch2 gets bits 0,1,0, interleaved via the RR. Required:
  - ch1 res_out = 1,1,0 and ch2 res_out = 0,1,0
  - no cross-channel leakage
  - res_primed is first 1 on each channel's third sample
- Clear collision: ch0 primed with history {h1=1,h0=1}; assert clear[0] with grant and bit_in=1. Required:
  - res_out=1 and res_primed=0
  - next two ch0 samples 0,1 give res_out=0,0 and res_primed=0,1
- Idle and reset: req=0 for 3 cycles gives res_valid=0 and grant=0. Then with 3 channels requesting, pull reset low for one edge mid-stream. Required:
  - next cycle res_valid=0, res_out=0
  - after release, first grant goes to ch0 and every channel restarts with res_primed=0
